rt_pixel_seq: RTL and testbench
===============================

// Module: rt_pixel_seq
// PURPOSE
//  Frame-level pixel coordinate sequencer feeding the ray generation unit (rt_rgu).
//  - Walks a width x height image in raster order (x fastest).
//  - Emits one Q14.18 (x, y) pair per issue cycle together with the RGU start strobe.
//  - Honours a downstream ready signal (ray FIFO credit).
//  - Pulses frame_done once the last ray has left the RGU pipeline.
// PARAMETERS
//  COORD_W      32  width of x/y outputs (matches RGU fixed-point word)
//  FRAC_BITS    18  fractional bits of the coordinate format (Q14.18)
//  DIM_W        13  width of cfg_width/cfg_height; max dimension 8191, so coords stay positive
//  RGU_LATENCY   5  RGU start->valid latency in cycles, used for drain
// PORTS
//  clk          in   1        system clock
//  reset        in   1        synchronous, active-high reset
//  cfg_width    in   DIM_W    image width in pixels, sampled on accepted frame_start
//  cfg_height   in   DIM_W    image height in pixels, sampled on accepted frame_start
//  frame_start  in   1        single-cycle request to render one frame
//  abort        in   1        synchronous cancel of the current frame
//  out_ready    in   1        downstream can accept a ray this cycle
//  start        out  1        issue strobe to RGU; a pixel is consumed when start=1
//  x            out  COORD_W  pixel x, {zero-ext count, FRAC_BITS'b0}
//  y            out  COORD_W  pixel y, same format
//  busy         out  1        state != IDLE
//  frame_done   out  1        1-cycle pulse at end of frame
// BEHAVIOUR
//  - Clocking and reset
//    - One clock, clk. reset is synchronous and active-high.
//    - Reset values: start=0, x=0, y=0, busy=0, frame_done=0, state=IDLE, all counters 0.
//    - Reset asserted mid-frame discards the frame; no frame_done.
//  - FSM states: IDLE, RUN, DRAIN, DONE.
//    - IDLE->RUN: frame_start=1, cfg_width!=0 and cfg_height!=0. Latch dims; x_cnt=y_cnt=0.
//    - IDLE->DONE: frame_start=1 with either dim 0. No start is issued.
//    - RUN: start = out_ready (combinational, state==RUN). x/y are registered, stable while stalled.
//      - On issue with x_cnt<W-1: x_cnt++.
//      - On issue with x_cnt==W-1: x_cnt=0, y_cnt++.
//      - Issue of pixel (W-1,H-1): go to DRAIN with drain_cnt=RGU_LATENCY-1.
//    - DRAIN: start=0. drain_cnt decrements each cycle; at 0 go to DONE.
//    - DONE: frame_done=1 for exactly one cycle, then IDLE.
//  - Timing
//    - frame_done is asserted RGU_LATENCY+1 cycles after the final start cycle.
//    - This places frame_done one cycle after the last RGU valid.
//    - First start may assert on the cycle after frame_start is accepted.
//  - Input rules
//    - frame_start while busy is ignored; latched dims are unaffected.
//    - abort in RUN or DRAIN: IDLE next cycle. start=0 from that cycle on; no frame_done.
//    - abort has priority over issue in the same cycle. That pixel is still consumed, because start is combinational.
//    - abort in IDLE or DONE has no effect.
//  - Arithmetic: x_cnt/y_cnt are DIM_W-bit unsigned. Outputs are the counter zero-extended to COORD_W-FRAC_BITS bits, then shifted left by FRAC_BITS. No rounding.
// STRUCTURE
//  - rt_pkg holds:
//    - typedef seq_state_e {IDLE,RUN,DRAIN,DONE}
//    - localparam FRAC_BITS
//    - function to_fixed(): int -> Q14.18
//  - One sub-module, rt_raster_cnt: 2-D wrap counter with inputs en, width, height and outputs x_cnt, y_cnt, last.
//  - FSM and drain counter live in rt_pixel_seq.
// TESTING
//  - 3x2 frame, out_ready=1:
//    - start high 6 consecutive cycles.
//    - x = 0,0x40000,0x80000 repeated; y = 0 x3 then 0x40000 x3.
//    - frame_done exactly 6 cycles after the last start.
//  - 3x2 frame, out_ready=0 on cycles 2-4 of RUN:
//    - start=0 and x/y held during the stall.
//    - Same 6-pixel sequence, frame_done 6 cycles after the last start.
//  - 1x1 frame: a single start with x=y=0, busy high until frame_done.
//  - cfg_width=0, height=4: no start; frame_done pulses 1 cycle after frame_start.
//  - frame_start re-pulsed mid-RUN with other dims: ignored, original pixel count issued.
//  - abort mid-RUN, then reset mid-RUN of a new frame: both return to IDLE, no frame_done, all outputs 0 after reset.

Source files
------------

// File: rtl/rt_pkg.sv
// Shared types and fixed-point helpers for the ray-tracer pixel front end.
package rt_pkg;

  localparam int unsigned FRAC_BITS = 18;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } seq_state_e;

  // Integer pixel index to unsigned fixed point; callers truncate to their word width.
  function automatic logic [63:0] to_fixed(input int unsigned v,
                                           input int unsigned frac = FRAC_BITS);
    return 64'(v) << frac;
  endfunction

endpackage

// File: rtl/rt_raster_cnt.sv
// 2-D raster counter: x advances on each enable, wraps into y; flags the final pixel.
module rt_raster_cnt #(
  parameter int unsigned DIM_W = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  output logic [DIM_W-1:0] x_cnt,
  output logic [DIM_W-1:0] y_cnt,
  output logic             last
);

  logic x_end;
  logic y_end;

  assign x_end = (x_cnt == width - DIM_W'(1));
  assign y_end = (y_cnt == height - DIM_W'(1));
  assign last  = x_end && y_end;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (en) begin
      if (x_end) begin
        x_cnt <= '0;
        y_cnt <= y_end ? '0 : y_cnt + DIM_W'(1);
      end else begin
        x_cnt <= x_cnt + DIM_W'(1);
      end
    end
  end

endmodule

// File: rtl/rt_pixel_seq.sv
// Frame-level raster sequencer issuing fixed-point (x, y) pairs to the ray generation unit.
module rt_pixel_seq #(
  parameter int unsigned COORD_W     = 32,
  parameter int unsigned FRAC_BITS   = 18,
  parameter int unsigned DIM_W       = 13,
  parameter int unsigned RGU_LATENCY = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIM_W-1:0]   cfg_width,
  input  logic [DIM_W-1:0]   cfg_height,
  input  logic               frame_start,
  input  logic               abort,
  input  logic               out_ready,
  output logic               start,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               busy,
  output logic               frame_done
);

  import rt_pkg::*;

  localparam int unsigned DRAIN_W = (RGU_LATENCY > 1) ? $clog2(RGU_LATENCY) : 1;

  seq_state_e         state;
  logic [DIM_W-1:0]   w_lat;
  logic [DIM_W-1:0]   h_lat;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [DIM_W-1:0]   x_cnt;
  logic [DIM_W-1:0]   y_cnt;
  logic               last;
  logic               accept;

  assign accept = (state == IDLE) && frame_start;

  // Combinational so a ready credit is consumed in the same cycle, even if abort is also high.
  assign start = (state == RUN) && out_ready;

  rt_raster_cnt #(
    .DIM_W(DIM_W)
  ) u_raster (
    .clk   (clk),
    .reset (reset),
    .clr   (accept || abort),
    .en    (start),
    .width (w_lat),
    .height(h_lat),
    .x_cnt (x_cnt),
    .y_cnt (y_cnt),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      w_lat     <= '0;
      h_lat     <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            w_lat <= cfg_width;
            h_lat <= cfg_height;
            state <= (cfg_width != '0 && cfg_height != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (start && last) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_W'(RGU_LATENCY - 1);
          end
        end
        DRAIN: begin
          if (abort) begin
            state <= IDLE;
          end else if (drain_cnt == '0) begin
            state <= DONE;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign x          = COORD_W'(to_fixed(32'(x_cnt), FRAC_BITS));
  assign y          = COORD_W'(to_fixed(32'(y_cnt), FRAC_BITS));
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

endmodule

// File: tb/tb_rt_pixel_seq.sv
// Directed bench for rt_pixel_seq: a cycle table for a stalled 3x2 frame plus corner sequences.
module tb_rt_pixel_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] cfg_width;
  logic [12:0] cfg_height;
  logic        frame_start;
  logic        abort;
  logic        out_ready;
  logic        start;
  logic [31:0] x;
  logic [31:0] y;
  logic        busy;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rt_pixel_seq #(
    .COORD_W    (32),
    .FRAC_BITS  (18),
    .DIM_W      (13),
    .RGU_LATENCY(5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .frame_start(frame_start),
    .abort      (abort),
    .out_ready  (out_ready),
    .start      (start),
    .x          (x),
    .y          (y),
    .busy       (busy),
    .frame_done (frame_done)
  );

  typedef struct {
    logic        fs;
    logic        rdy;
    logic        e_start;
    logic        e_busy;
    logic        e_done;
    logic        chk_xy;
    logic [31:0] ex;
    logic [31:0] ey;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic fs, logic rdy, logic es, logic eb, logic ed,
                              logic cxy, logic [31:0] ex, logic [31:0] ey);
    vec_t v;
    v.fs = fs; v.rdy = rdy; v.e_start = es; v.e_busy = eb; v.e_done = ed;
    v.chk_xy = cxy; v.ex = ex; v.ey = ey;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame with out_ready held high; optionally re-pulses frame_start mid-frame.
  task automatic run_frame(input int w, input int h, input int repulse_at, input int exp_n);
    int n;
    int last_cyc;
    int cyc;
    bit done_seen;
    bit busy_ok;
    cfg_width   = 13'(w);
    cfg_height  = 13'(h);
    frame_start = 1'b1;
    out_ready   = 1'b1;
    next_cycle();
    frame_start = 1'b0;
    n = 0; last_cyc = -1; cyc = 0; done_seen = 0; busy_ok = 1;
    while (cyc < 200 && !done_seen) begin
      if (cyc == repulse_at) begin
        frame_start = 1'b1;
        cfg_width   = 13'd7;
        cfg_height  = 13'd5;
      end else begin
        frame_start = 1'b0;
      end
      @(negedge clk);
      if (start) begin
        check($sformatf("frame%0dx%0d_x[%0d]", w, h, n), 64'(x), 64'((n % w) << 18));
        check($sformatf("frame%0dx%0d_y[%0d]", w, h, n), 64'(y), 64'((n / w) << 18));
        n++;
        last_cyc = cyc;
      end
      if (!busy) busy_ok = 0;
      if (frame_done) begin
        done_seen = 1;
        check($sformatf("frame%0dx%0d_done_delay", w, h), 64'(cyc - last_cyc), 64'd6);
      end
      next_cycle();
      cyc++;
    end
    frame_start = 1'b0;
    check($sformatf("frame%0dx%0d_done_seen", w, h), 64'(done_seen), 64'd1);
    check($sformatf("frame%0dx%0d_pixels", w, h), 64'(n), 64'(exp_n));
    check($sformatf("frame%0dx%0d_last_start_cyc", w, h), 64'(last_cyc), 64'(exp_n - 1));
    check($sformatf("frame%0dx%0d_busy_held", w, h), 64'(busy_ok), 64'd1);
    @(negedge clk);
    check($sformatf("frame%0dx%0d_done_one_cycle", w, h), 64'(frame_done), 64'd0);
    check($sformatf("frame%0dx%0d_idle_after", w, h), 64'(busy), 64'd0);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit done_any;
    reset = 1'b1; cfg_width = '0; cfg_height = '0;
    frame_start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("reset_start", 64'(start), 64'd0);
    check("reset_x", 64'(x), 64'd0);
    check("reset_y", 64'(y), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(frame_done), 64'd0);
    reset = 1'b0;
    next_cycle();

    // 3x2 frame, out_ready low on RUN cycles 2-4
    vecs[0]  = mk(1, 1, 0, 0, 0, 1, 32'h0, 32'h0);
    vecs[1]  = mk(0, 1, 1, 1, 0, 1, 32'h0, 32'h0);
    vecs[2]  = mk(0, 0, 0, 1, 0, 1, 32'h40000, 32'h0);
    vecs[3]  = mk(0, 0, 0, 1, 0, 1, 32'h40000, 32'h0);
    vecs[4]  = mk(0, 0, 0, 1, 0, 1, 32'h40000, 32'h0);
    vecs[5]  = mk(0, 1, 1, 1, 0, 1, 32'h40000, 32'h0);
    vecs[6]  = mk(0, 1, 1, 1, 0, 1, 32'h80000, 32'h0);
    vecs[7]  = mk(0, 1, 1, 1, 0, 1, 32'h0, 32'h40000);
    vecs[8]  = mk(0, 1, 1, 1, 0, 1, 32'h40000, 32'h40000);
    vecs[9]  = mk(0, 1, 1, 1, 0, 1, 32'h80000, 32'h40000);
    for (int i = 10; i < 15; i++) vecs[i] = mk(0, 1, 0, 1, 0, 0, 32'h0, 32'h0);
    vecs[15] = mk(0, 1, 0, 1, 1, 0, 32'h0, 32'h0);
    vecs[16] = mk(0, 1, 0, 0, 0, 0, 32'h0, 32'h0);

    cfg_width = 13'd3; cfg_height = 13'd2;
    for (int i = 0; i < 17; i++) begin
      frame_start = vecs[i].fs;
      out_ready   = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("stall_start[%0d]", i), 64'(start), 64'(vecs[i].e_start));
      check($sformatf("stall_busy[%0d]", i), 64'(busy), 64'(vecs[i].e_busy));
      check($sformatf("stall_done[%0d]", i), 64'(frame_done), 64'(vecs[i].e_done));
      if (vecs[i].chk_xy) begin
        check($sformatf("stall_x[%0d]", i), 64'(x), 64'(vecs[i].ex));
        check($sformatf("stall_y[%0d]", i), 64'(y), 64'(vecs[i].ey));
      end
      next_cycle();
    end
    frame_start = 1'b0;

    run_frame(3, 2, -1, 6);
    run_frame(1, 1, -1, 1);
    run_frame(3, 2, 2, 6);

    // zero width: straight to DONE, no issue
    cfg_width = 13'd0; cfg_height = 13'd4; out_ready = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    check("zero_start_c0", 64'(start), 64'd0);
    next_cycle();
    frame_start = 1'b0;
    @(negedge clk);
    check("zero_done_c1", 64'(frame_done), 64'd1);
    check("zero_start_c1", 64'(start), 64'd0);
    check("zero_busy_c1", 64'(busy), 64'd1);
    next_cycle();
    @(negedge clk);
    check("zero_done_c2", 64'(frame_done), 64'd0);
    check("zero_busy_c2", 64'(busy), 64'd0);
    next_cycle();

    // abort mid-RUN: pixel in the abort cycle is still issued, then idle with no frame_done
    cfg_width = 13'd3; cfg_height = 13'd2; frame_start = 1'b1;
    next_cycle();
    frame_start = 1'b0;
    next_cycle();
    next_cycle();
    abort = 1'b1;
    @(negedge clk);
    check("abort_start_same_cycle", 64'(start), 64'd1);
    check("abort_x_same_cycle", 64'(x), 64'h80000);
    next_cycle();
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_start", 64'(start), 64'd0);
    done_any = 0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      @(negedge clk);
      if (frame_done || start) done_any = 1;
    end
    check("abort_no_done", 64'(done_any), 64'd0);
    next_cycle();

    // reset mid-RUN of a new frame
    frame_start = 1'b1;
    next_cycle();
    frame_start = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_start", 64'(start), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_x", 64'(x), 64'd0);
    check("rst_mid_y", 64'(y), 64'd0);
    check("rst_mid_done", 64'(frame_done), 64'd0);
    done_any = 0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      @(negedge clk);
      if (frame_done || start) done_any = 1;
    end
    check("rst_mid_no_done", 64'(done_any), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
